// File: rtl/lsq_mem_ctrl.sv
// lsq_mem_ctrl: sequences LSQ head accesses onto dmem and loaded data onto the CDB.
// Optional dmem watchdog enabled by defining LSQ_CTRL_TIMEOUT_EN.
module lsq_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsq_head_ready,
    input  logic              lsq_head_load,
    input  logic              lsq_empty,
    input  logic [ADDR_W-1:0] lsq_head_addr,
    input  logic [DATA_W-1:0] lsq_head_data,
    input  logic [TAG_W-1:0]  lsq_head_tag,
    output logic              lsq_rd_en,
    input  logic              rob_head_valid,
    input  logic [TAG_W-1:0]  rob_head_tag,
    output logic              store_done,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant,
    output logic              mem_err
);

    typedef enum logic [2:0] {
        IDLE,
        LD_MEM,
        LD_CDB,
        ST_MEM,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ld_go;
    logic              st_go;
    logic              capture;
    logic              timeout;

    assign ld_go = !lsq_empty && lsq_head_ready && lsq_head_load && !flush;

    // A store may only touch memory once the ROB says it is the oldest instruction.
    assign st_go = !lsq_empty && lsq_head_ready && !lsq_head_load
                   && rob_head_valid && (rob_head_tag == lsq_head_tag)
                   && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake pulses.
    always_comb begin
        state_next = state;
        lsq_rd_en  = 1'b0;
        store_done = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_go) begin
                    state_next = LD_MEM;
                end else if (st_go) begin
                    state_next = ST_MEM;
                end
            end
            LD_MEM: begin
                if (dmem_ready) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = LD_CDB;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            LD_CDB: begin
                // Flush wins over a same-cycle grant: the load is squashed.
                if (flush) begin
                    state_next = IDLE;
                end else if (cdb_grant) begin
                    lsq_rd_en  = 1'b1;
                    state_next = IDLE;
                end
            end
            ST_MEM: begin
                // The store is already architecturally committed, so flush is ignored.
                if (dmem_ready) begin
                    lsq_rd_en  = 1'b1;
                    store_done = 1'b1;
                    state_next = IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (dmem_ready || timeout) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the head on launch and the read data on load completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && state_next != IDLE) begin
                addr_q  <= lsq_head_addr;
                wdata_q <= lsq_head_data;
                tag_q   <= lsq_head_tag;
            end
            if (capture) begin
                rdata_q <= dmem_rdata;
            end
        end
    end

    assign dmem_req   = (state == LD_MEM) || (state == ST_MEM) || (state == DRAIN);
    assign dmem_we    = (state == ST_MEM);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign cdb_req    = (state == LD_CDB);
    assign cdb_tag    = tag_q;
    assign cdb_data   = rdata_q;

`ifdef LSQ_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             waiting;

    assign waiting = dmem_req && !dmem_ready;
    assign timeout = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Count consecutive stalled request cycles; abort and flag on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_next != state || !waiting) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout && !(state == LD_MEM && flush)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_err = err_q;
`else
    // TIMEOUT only matters to the watchdog build.
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// tb_lsq_mem_ctrl: directed checks of lsq_mem_ctrl load/store/flush/reset flows.
// Watchdog section depends on LSQ_CTRL_TIMEOUT_EN.
module tb_lsq_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsq_head_ready;
    logic        lsq_head_load;
    logic        lsq_empty;
    logic [31:0] lsq_head_addr;
    logic [31:0] lsq_head_data;
    logic [3:0]  lsq_head_tag;
    logic        lsq_rd_en;
    logic        rob_head_valid;
    logic [3:0]  rob_head_tag;
    logic        store_done;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        cdb_req;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int sd_cnt   = 0;
    int r0;
    int s0;

    lsq_mem_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TAG_W   (4),
        .TIMEOUT (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lsq_head_ready (lsq_head_ready),
        .lsq_head_load  (lsq_head_load),
        .lsq_empty      (lsq_empty),
        .lsq_head_addr  (lsq_head_addr),
        .lsq_head_data  (lsq_head_data),
        .lsq_head_tag   (lsq_head_tag),
        .lsq_rd_en      (lsq_rd_en),
        .rob_head_valid (rob_head_valid),
        .rob_head_tag   (rob_head_tag),
        .store_done     (store_done),
        .flush          (flush),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ready     (dmem_ready),
        .cdb_req        (cdb_req),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_grant      (cdb_grant),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    // Count dequeue and retire pulses as seen by the LSQ/ROB.
    always @(posedge clk) begin
        if (lsq_rd_en === 1'b1) rd_cnt++;
        if (store_done === 1'b1) sd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic head_load(input logic [31:0] a, input logic [3:0] t);
        lsq_empty      = 1'b0;
        lsq_head_ready = 1'b1;
        lsq_head_load  = 1'b1;
        lsq_head_addr  = a;
        lsq_head_tag   = t;
    endtask

    task automatic head_none();
        lsq_empty      = 1'b1;
        lsq_head_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        lsq_head_ready = 1'b0;
        lsq_head_load  = 1'b0;
        lsq_empty      = 1'b1;
        lsq_head_addr  = '0;
        lsq_head_data  = '0;
        lsq_head_tag   = '0;
        rob_head_valid = 1'b0;
        rob_head_tag   = '0;
        flush          = 1'b0;
        dmem_rdata     = '0;
        dmem_ready     = 1'b0;
        cdb_grant      = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_cdb_req", cdb_req, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_rd_en", lsq_rd_en, 0);
        chk("rst_store_done", store_done, 0);
        chk("rst_mem_err", mem_err, 0);
        reset = 1'b0;

        // load, 2 wait cycles, immediate grant
        r0 = rd_cnt;
        @(negedge clk); head_load(32'h40, 4'd3); #1;
        chk("t1_idle_req", dmem_req, 0);
        @(negedge clk); head_none(); lsq_head_addr = 32'h99; lsq_head_tag = 4'd7; #1;
        chk("t1_w1_req", dmem_req, 1);
        chk("t1_w1_we", dmem_we, 0);
        chk("t1_w1_addr", dmem_addr, 32'h40);
        @(negedge clk); #1;
        chk("t1_w2_req", dmem_req, 1);
        @(negedge clk); dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
        chk("t1_rdy_req", dmem_req, 1);
        chk("t1_rdy_cdb_req", cdb_req, 0);
        chk("t1_rdy_rd_en", lsq_rd_en, 0);
        @(negedge clk); dmem_ready = 1'b0; dmem_rdata = '0; cdb_grant = 1'b1; #1;
        chk("t1_cdb_req", cdb_req, 1);
        chk("t1_cdb_tag", cdb_tag, 3);
        chk("t1_cdb_data", cdb_data, 32'hDEADBEEF);
        chk("t1_rd_en", lsq_rd_en, 1);
        chk("t1_cdb_dmem_req", dmem_req, 0);
        @(negedge clk); cdb_grant = 1'b0; #1;
        chk("t1_idle_cdb_req", cdb_req, 0);
        chk("t1_rd_count", rd_cnt - r0, 1);

        // store waits for ROB head tag match
        r0 = rd_cnt; s0 = sd_cnt;
        @(negedge clk);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_load = 1'b0;
        lsq_head_addr = 32'h80; lsq_head_data = 32'h12345678; lsq_head_tag = 4'd5;
        rob_head_valid = 1'b1; rob_head_tag = 4'd2; #1;
        chk("t2_mismatch0_req", dmem_req, 0);
        @(negedge clk); #1;
        chk("t2_mismatch1_req", dmem_req, 0);
        @(negedge clk); rob_head_tag = 4'd5; #1;
        chk("t2_mismatch2_req", dmem_req, 0);
        @(negedge clk); head_none(); rob_head_valid = 1'b0; dmem_ready = 1'b1; #1;
        chk("t2_st_req", dmem_req, 1);
        chk("t2_st_we", dmem_we, 1);
        chk("t2_st_addr", dmem_addr, 32'h80);
        chk("t2_st_wdata", dmem_wdata, 32'h12345678);
        chk("t2_store_done", store_done, 1);
        chk("t2_rd_en", lsq_rd_en, 1);
        @(negedge clk); dmem_ready = 1'b0; #1;
        chk("t2_idle_req", dmem_req, 0);
        chk("t2_idle_store_done", store_done, 0);
        chk("t2_sd_count", sd_cnt - s0, 1);
        chk("t2_rd_count", rd_cnt - r0, 1);

        // grant withheld for 4 cycles
        @(negedge clk); head_load(32'h100, 4'd9); #1;
        @(negedge clk); head_none(); dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
        chk("t3_mem_req", dmem_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmem_ready = 1'b0; dmem_rdata = '0; cdb_grant = 1'b0; #1;
            chk("t3_hold_cdb_req", cdb_req, 1);
            chk("t3_hold_tag", cdb_tag, 9);
            chk("t3_hold_data", cdb_data, 32'hCAFEF00D);
            chk("t3_hold_rd_en", lsq_rd_en, 0);
        end
        @(negedge clk); cdb_grant = 1'b1; #1;
        chk("t3_grant_rd_en", lsq_rd_en, 1);
        chk("t3_grant_data", cdb_data, 32'hCAFEF00D);
        @(negedge clk); cdb_grant = 1'b0; #1;
        chk("t3_idle_cdb_req", cdb_req, 0);

        // flush in second LD_MEM wait cycle -> DRAIN
        r0 = rd_cnt;
        @(negedge clk); head_load(32'h200, 4'd4); #1;
        @(negedge clk); head_none(); #1;
        chk("t4_w1_req", dmem_req, 1);
        @(negedge clk); flush = 1'b1; #1;
        chk("t4_w2_req", dmem_req, 1);
        @(negedge clk); flush = 1'b0; #1;
        chk("t4_drain_req", dmem_req, 1);
        chk("t4_drain_we", dmem_we, 0);
        chk("t4_drain_cdb_req", cdb_req, 0);
        @(negedge clk); dmem_ready = 1'b1; dmem_rdata = 32'h0BADBAD0; #1;
        chk("t4_drain_rdy_req", dmem_req, 1);
        chk("t4_drain_rd_en", lsq_rd_en, 0);
        @(negedge clk); dmem_ready = 1'b0; #1;
        chk("t4_idle_req", dmem_req, 0);
        chk("t4_idle_cdb_req", cdb_req, 0);
        chk("t4_cdb_data_kept", cdb_data, 32'hCAFEF00D);
        chk("t4_rd_count", rd_cnt - r0, 0);

        // flush during ST_MEM is ignored
        s0 = sd_cnt;
        @(negedge clk);
        lsq_empty = 1'b0; lsq_head_ready = 1'b1; lsq_head_load = 1'b0;
        lsq_head_addr = 32'h300; lsq_head_data = 32'hA5A5A5A5; lsq_head_tag = 4'd6;
        rob_head_valid = 1'b1; rob_head_tag = 4'd6; #1;
        @(negedge clk); head_none(); flush = 1'b1; #1;
        chk("t5_st_req", dmem_req, 1);
        chk("t5_st_we", dmem_we, 1);
        chk("t5_st_wait_done", store_done, 0);
        @(negedge clk); dmem_ready = 1'b1; #1;
        chk("t5_store_done", store_done, 1);
        chk("t5_rd_en", lsq_rd_en, 1);
        chk("t5_wdata", dmem_wdata, 32'hA5A5A5A5);
        @(negedge clk); flush = 1'b0; dmem_ready = 1'b0; rob_head_valid = 1'b0; #1;
        chk("t5_idle_req", dmem_req, 0);
        chk("t5_sd_count", sd_cnt - s0, 1);

        // back-to-back load, store, load
        r0 = rd_cnt;
        dmem_ready = 1'b1; cdb_grant = 1'b1;
        @(negedge clk); head_load(32'h10, 4'd1); dmem_rdata = 32'h11111111; #1;
        chk("t6_c0_rd_en", lsq_rd_en, 0);
        @(negedge clk); #1;
        chk("t6_c1_rd_en", lsq_rd_en, 0);
        chk("t6_c1_addr", dmem_addr, 32'h10);
        @(negedge clk);
        lsq_head_load = 1'b0; lsq_head_addr = 32'h20; lsq_head_data = 32'h22222222;
        lsq_head_tag = 4'd2; rob_head_valid = 1'b1; rob_head_tag = 4'd2; #1;
        chk("t6_c2_rd_en", lsq_rd_en, 1);
        chk("t6_c2_tag", cdb_tag, 1);
        chk("t6_c2_data", cdb_data, 32'h11111111);
        @(negedge clk); #1;
        chk("t6_c3_rd_en", lsq_rd_en, 0);
        chk("t6_c3_req", dmem_req, 0);
        @(negedge clk); head_load(32'h30, 4'd3); dmem_rdata = 32'h33333333; #1;
        chk("t6_c4_rd_en", lsq_rd_en, 1);
        chk("t6_c4_store_done", store_done, 1);
        chk("t6_c4_we", dmem_we, 1);
        chk("t6_c4_addr", dmem_addr, 32'h20);
        @(negedge clk); #1;
        chk("t6_c5_rd_en", lsq_rd_en, 0);
        @(negedge clk); #1;
        chk("t6_c6_rd_en", lsq_rd_en, 0);
        chk("t6_c6_addr", dmem_addr, 32'h30);
        @(negedge clk); head_none(); rob_head_valid = 1'b0; #1;
        chk("t6_c7_rd_en", lsq_rd_en, 1);
        chk("t6_c7_tag", cdb_tag, 3);
        chk("t6_c7_data", cdb_data, 32'h33333333);
        @(negedge clk); dmem_ready = 1'b0; cdb_grant = 1'b0; #1;
        chk("t6_rd_count", rd_cnt - r0, 3);
        chk("t6_idle_req", dmem_req, 0);

        // reset mid-LD_MEM
        @(negedge clk); head_load(32'h44, 4'd5); #1;
        @(negedge clk); head_none(); reset = 1'b1; #1;
        chk("t7_pre_req", dmem_req, 1);
        @(negedge clk); #1;
        chk("t7_req", dmem_req, 0);
        chk("t7_addr", dmem_addr, 0);
        chk("t7_cdb_tag", cdb_tag, 0);
        chk("t7_cdb_data", cdb_data, 0);
        chk("t7_cdb_req", cdb_req, 0);
        chk("t7_rd_en", lsq_rd_en, 0);
        @(negedge clk); reset = 1'b0; #1;

        // flush beats a same-cycle grant
        r0 = rd_cnt;
        @(negedge clk); head_load(32'h70, 4'd7); #1;
        @(negedge clk); head_none(); dmem_ready = 1'b1; dmem_rdata = 32'h77777777; #1;
        @(negedge clk); dmem_ready = 1'b0; cdb_grant = 1'b1; flush = 1'b1; #1;
        chk("t8_cdb_req", cdb_req, 1);
        chk("t8_rd_en", lsq_rd_en, 0);
        @(negedge clk); cdb_grant = 1'b0; flush = 1'b0; #1;
        chk("t8_idle_cdb_req", cdb_req, 0);
        chk("t8_rd_count", rd_cnt - r0, 0);

        // dmem_ready stuck low
        r0 = rd_cnt;
        @(negedge clk); head_load(32'h50, 4'd2); #1;
`ifdef LSQ_CTRL_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); head_none(); #1;
            chk("t9_wait_req", dmem_req, 1);
            chk("t9_wait_err", mem_err, 0);
        end
        @(negedge clk); #1;
        chk("t9_to_req", dmem_req, 0);
        chk("t9_to_err", mem_err, 1);
        chk("t9_to_cdb_req", cdb_req, 0);
        chk("t9_to_rd_count", rd_cnt - r0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t9_err_sticky", mem_err, 1);
        chk("t9_idle_req", dmem_req, 0);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); head_none(); #1;
            chk("t9_wait_req", dmem_req, 1);
            chk("t9_wait_err", mem_err, 0);
        end
        @(negedge clk); dmem_ready = 1'b1; dmem_rdata = 32'h55555555; #1;
        chk("t9_rdy_rd_en", lsq_rd_en, 0);
        @(negedge clk); dmem_ready = 1'b0; cdb_grant = 1'b1; #1;
        chk("t9_rd_en", lsq_rd_en, 1);
        chk("t9_data", cdb_data, 32'h55555555);
        @(negedge clk); cdb_grant = 1'b0; #1;
        chk("t9_idle_cdb_req", cdb_req, 0);
        chk("t9_err", mem_err, 0);
        chk("t9_rd_count", rd_cnt - r0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
